dsm_mash: RTL

- Parametrised digital delta-sigma modulator. Accumulators are built from chained full-adder ripple stages.
- Converts an unsigned WIDTH-bit input word into a low-resolution output stream whose time average equals din/2^WIDTH.
- ORDER=1 gives a first-order single-accumulator modulator. ORDER=2 gives a MASH 1-1 cascade with digital noise-cancellation.
- Sits between the sample source and the DAC/output driver in the DeltaSigma datapath.

---
 rtl/dsm_pkg.sv | 23 ++
 rtl/dsm_mash_rca_adder.sv | 44 ++++
 rtl/dsm_mash.sv | 108 ++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
// Module : dsm_pkg
// Brief  : Shared constants and output-range helpers for the dsm_mash modulator.
// Rev    : 1.0  initial release
// ============================================================================
package dsm_pkg;

    localparam int DOUT_W    = 3;
    localparam int ORDER_MIN = 1;
    localparam int ORDER_MAX = 2;

    // MASH 1-1 spans -1..+2; the single-accumulator loop only emits its carry.
    function automatic int dout_min(input int order);
        return (order == 2) ? -1 : 0;
    endfunction

    function automatic int dout_max(input int order);
        return (order == 2) ? 2 : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_mash_rca_adder.sv
`default_nettype none
// ============================================================================
// Module : dsm_fa / rca_adder
// Brief  : 1-bit full-adder cell and a WIDTH-bit ripple-carry adder built from it.
// Rev    : 1.0  initial release
// ============================================================================
module dsm_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module rca_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;
    assign cout       = w_carry[WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            dsm_fa u_fa (
                .i_a    (a[gi]),
                .i_b    (b[gi]),
                .i_cin  (w_carry[gi]),
                .o_sum  (sum[gi]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/dsm_mash.sv
`default_nettype none
// ============================================================================
// Module : dsm_mash
// Brief  : First-order or MASH 1-1 digital delta-sigma modulator, 3-bit output.
// Rev    : 1.0  initial release
// ============================================================================
module dsm_mash
    import dsm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ORDER = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  din,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    output logic              ovf_c1
);
    generate
        if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
            $error("dsm_mash: ORDER must be 1 or 2");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("dsm_mash: WIDTH must be in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0]  r_acc1;
    logic [WIDTH-1:0]  w_s1;
    logic              w_c1;
    logic [DOUT_W-1:0] w_y;
    logic [DOUT_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_ovf_c1;

    rca_adder #(.WIDTH(WIDTH)) u_add1 (
        .a    (r_acc1),
        .b    (din),
        .cin  (1'b0),
        .sum  (w_s1),
        .cout (w_c1)
    );

    generate
        if (ORDER == 2) begin : g_mash11
            logic [WIDTH-1:0] r_acc2;
            logic [WIDTH-1:0] w_s2;
            logic             w_c2;
            logic             r_c2_d;

            // Stage 2 integrates the freshly computed stage-1 sum, not the old acc1.
            rca_adder #(.WIDTH(WIDTH)) u_add2 (
                .a    (r_acc2),
                .b    (w_s1),
                .cin  (1'b0),
                .sum  (w_s2),
                .cout (w_c2)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc2 <= '0;
                    r_c2_d <= 1'b0;
                end else if (clr) begin
                    r_acc2 <= '0;
                    r_c2_d <= 1'b0;
                end else if (en) begin
                    r_acc2 <= w_s2;
                    r_c2_d <= w_c2;
                end
            end

            // 3-bit modular arithmetic yields the two's-complement -1..+2 directly.
            assign w_y = DOUT_W'(w_c1) + DOUT_W'(w_c2) - DOUT_W'(r_c2_d);
        end else begin : g_first_order
            assign w_y = DOUT_W'(w_c1);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc1       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf_c1     <= 1'b0;
        end else if (clr) begin
            r_acc1       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf_c1     <= 1'b0;
        end else if (en) begin
            r_acc1       <= w_s1;
            r_dout       <= w_y;
            r_dout_valid <= 1'b1;
            r_ovf_c1     <= w_c1;
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign ovf_c1     = r_ovf_c1;
endmodule
`default_nettype wire
